jt12_mix_acc: RTL and testbench
===============================

// Module: jt12_mix_acc
// PURPOSE
// - Parametrised stereo sample accumulator for JT12/JT10 FM cores: sums carrier-operator output over one 24-slot frame, plus NEXT external sample streams (ADPCM-A/B, PCM).
// - Each external stream is injected at a programmable slot, either added to or replacing that slot's FM data. Gain is a per-stream shift.
// - Saturates internally and at the output. Registers one stereo sample per frame, with a valid strobe and clip flags.
// - Sits between the operator pipeline and the output DAC/filter; successor to the fixed 2-input YM2610 mixer.
// PARAMETERS
// - WIN   14  operator result width (signed)
// - EXTW  16  external sample width (signed)
// - NEXT   2  number of external stereo streams (1..4)
// - WACC  19  internal accumulator width; must be >= WOUT+2
// - WOUT  16  output sample width (signed)
// PORTS
// - clk         in   1          system clock
// - rst_n       in   1          asynchronous active-low reset
// - clk_en      in   1          slot strobe; all state advances only when high
// - op_result   in   WIN        signed operator output for current slot
// - rl          in   2          [1]=left enable, [0]=right enable for current channel
// - alg         in   3          current channel algorithm
// - s1_enters..s4_enters in 1 each  operator-slot identifiers
// - cur_ch      in   3          current channel
// - cur_op      in   2          current operator
// - zero        in   1          first slot of frame (with clk_en)
// - ext_l/ext_r in   NEXT*EXTW  signed external samples, stream i at [i*EXTW+:EXTW]
// - ext_ch      in   NEXT*3     channel slot (cur_op==0) where stream i is injected
// - ext_sh      in   NEXT*3     left-shift 0..7 for stream i
// - ext_rep     in   NEXT       1: stream i replaces FM data of its slot; 0: adds to it
// - ext_mute    in   NEXT       1: stream i contributes 0
// - left/right  out  WOUT       registered frame sample
// - out_valid   out  1          one-clk pulse when left/right update
// - clip_l/clip_r out 1         saturation occurred in the frame just output; valid with out_valid
// BEHAVIOUR
// - Reset: left=right=0; out_valid=0; clip_l/r=0; accumulators=0; primed=0; peak regs=0.
// - clk_en low: all state holds; out_valid=0.
// - FM term: sum_en by alg per JT12 rule:
//   - alg 0-3: s4
//   - alg 4: s2|s4
//   - alg 5,6: ~s1
//   - alg 7: 1
// - FM term = sext(op_result) when sum_en & rl side bit, else 0.
//   - Dropped if any unmuted stream with ext_rep=1 matches {cur_op==0, cur_ch==ext_ch[i]}.
// - Ext term i = (sext(ext)<<<ext_sh[i])>>>2, computed at WACC bits.
//   - Added when slot matches and the stream is unmuted.
//   - Multiple streams on one slot all add.
// - Slot sum = FM term + all ext terms. acc_next = sat_WACC(acc + slot_sum).
// - Any saturation sets the side's sticky clip bit for the frame.
// - On clk_en & zero:
//   - left/right <= sat_WOUT(acc) of the ending frame; clip_l/r <= (sticky | output saturation).
//   - acc <= sat_WACC(slot_sum) (current slot starts the new frame); sticky cleared.
//   - out_valid pulses next clk only if primed=1; primed is then set.
//   - First zero after reset loads acc and sets primed, but does not raise out_valid (partial frame discarded).
//   - left/right still update on that first zero.
// - Latency: sample at left/right on clk after the zero slot; held until next zero.
// - Reset mid-frame: async clear, primed=0; the next frame rule above applies.
// - zero on consecutive clk_en cycles: each a 1-slot frame; legal.
// CONFIGURATION
// - JT12_ACC_PEAK_EN defined: adds ports peak_l/peak_r out WOUT-1 and peak_clr in 1.
//   - On each out_valid, peak <= max(peak, |left|), where |-2^(WOUT-1)| saturates to 2^(WOUT-1)-1.
//   - peak_clr (clk_en-independent) zeroes both peaks; same-cycle out_valid wins over the clear.
// - Not defined: ports and logic absent; all other behaviour identical.
// STRUCTURE
// - Package jt12_acc_pkg holds:
//   - functions alg_sum_en(), sat(val,width), ext_align()
//   - constant FRAME_SLOTS=24
// - Sub-module jt12_mix_lane (one per side) holds:
//   - ext summation, accumulator, sticky clip, output register
// - Top holds: sum_en decode, slot matching, primed flag, out_valid, peak option.
// TESTING
// - Reset then 24-slot frame: alg=7, rl=3, op=100 every slot, two zeros -> first zero no out_valid; second gives left=right=2400, out_valid=1, clip=0.
// - Stream0: ext_ch=2, ext_sh=6, ext_rep=1, ext_l=1000; FM op=500 in all slots, alg=7 -> left=23*500+16000=27500.
// - Saturation: alg=7, op=8191 each slot, 24 slots -> acc 196584; left=32767, clip_l=1; next frame with op=0 -> left=0, clip_l=0.
// - rl=2'b01, op=-200, alg=0, s4 once per frame -> left=0, right=-200; ext_mute=all -> ext contributions absent.
// - Reset asserted at slot 10, released at slot 15 -> no out_valid until second zero after release; outputs 0 meanwhile.
// - PEAK_EN: frames left=-32768 then 100 -> peak_l=32767; peak_clr -> 0.

Source files
------------

// File: rtl/jt12_acc_pkg.sv
// Shared helpers for the JT12 stereo frame accumulator: algorithm sum decode,
// generic saturation and external-sample alignment.
package jt12_acc_pkg;

  localparam int FRAME_SLOTS = 24;

  // Which operator slots are carriers, and so reach the output, for each algorithm
  function automatic logic alg_sum_en(input logic [2:0] alg, input logic s1,
                                      input logic s2, input logic s4);
    case (alg)
      3'd4:       return s2 | s4;
      3'd5, 3'd6: return ~s1;
      3'd7:       return 1'b1;
      default:    return s4;
    endcase
  endfunction

  function automatic logic signed [31:0] sat(input logic signed [31:0] val, input int width);
    logic signed [31:0] mx, mn;
    mx = (32'sd1 <<< (width - 1)) - 32'sd1;
    mn = -mx - 32'sd1;
    if (val > mx) return mx;
    if (val < mn) return mn;
    return val;
  endfunction

  // Shift wraps at 'width' bits (the accumulator width); >>>2 gives headroom
  function automatic logic signed [31:0] ext_align(input logic signed [31:0] ext,
                                                   input logic [2:0] sh, input int width);
    logic signed [31:0] v;
    v = ext <<< sh;
    v = (v <<< (32 - width)) >>> (32 - width);
    return v >>> 2;
  endfunction

endpackage

// File: rtl/jt12_mix_lane.sv
// One output side: adds external streams to the gated FM term, keeps the
// saturating frame accumulator, sticky clip flag and registered output.
module jt12_mix_lane
  import jt12_acc_pkg::*;
#(
  parameter int EXTW = 16,
  parameter int NEXT = 2,
  parameter int WACC = 19,
  parameter int WOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cen,
  input  logic                   i_zero,
  input  logic signed [WACC-1:0] i_fm,
  input  logic [NEXT*EXTW-1:0]   i_ext,
  input  logic [NEXT*3-1:0]      i_sh,
  input  logic [NEXT-1:0]        i_hit,
  output logic [WOUT-1:0]        o_out,
  output logic                   o_clip
);

  logic signed [WACC-1:0] r_acc;
  logic                   r_sticky;
  logic [WOUT-1:0]        r_out;
  logic                   r_clip;
  logic signed [31:0]     w_sum, w_tot, w_nx, w_osat;

  always_comb begin
    w_sum = 32'(i_fm);
    for (int i = 0; i < NEXT; i++)
      if (i_hit[i])
        w_sum = w_sum + ext_align(32'($signed(i_ext[i*EXTW +: EXTW])), i_sh[i*3 +: 3], WACC);
    // The zero slot opens the new frame instead of adding to the old one
    w_tot  = (i_zero ? 32'sd0 : 32'(r_acc)) + w_sum;
    w_nx   = sat(w_tot, WACC);
    w_osat = sat(32'(r_acc), WOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_out    <= '0;
      r_clip   <= 1'b0;
    end else if (i_cen) begin
      r_acc    <= w_nx[WACC-1:0];
      r_sticky <= (r_sticky & ~i_zero) | (w_nx != w_tot);
      if (i_zero) begin
        r_out  <= w_osat[WOUT-1:0];
        r_clip <= r_sticky | (w_osat != 32'(r_acc));
      end
    end
  end

  assign o_out  = r_out;
  assign o_clip = r_clip;

endmodule

// File: rtl/jt12_mix_acc.sv
// Stereo frame accumulator for JT12/JT10: FM carriers plus NEXT external streams.
// Optional peak meters enabled with JT12_ACC_PEAK_EN.
module jt12_mix_acc
  import jt12_acc_pkg::*;
#(
  parameter int WIN  = 14,
  parameter int EXTW = 16,
  parameter int NEXT = 2,
  parameter int WACC = 19,
  parameter int WOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clk_en,
  input  logic [WIN-1:0]       i_op_result,
  input  logic [1:0]           i_rl,
  input  logic [2:0]           i_alg,
  input  logic                 i_s1_enters,
  input  logic                 i_s2_enters,
  input  logic                 i_s3_enters,
  input  logic                 i_s4_enters,
  input  logic [2:0]           i_cur_ch,
  input  logic [1:0]           i_cur_op,
  input  logic                 i_zero,
  input  logic [NEXT*EXTW-1:0] i_ext_l,
  input  logic [NEXT*EXTW-1:0] i_ext_r,
  input  logic [NEXT*3-1:0]    i_ext_ch,
  input  logic [NEXT*3-1:0]    i_ext_sh,
  input  logic [NEXT-1:0]      i_ext_rep,
  input  logic [NEXT-1:0]      i_ext_mute,
`ifdef JT12_ACC_PEAK_EN
  input  logic                 i_peak_clr,
  output logic [WOUT-2:0]      o_peak_l,
  output logic [WOUT-2:0]      o_peak_r,
`endif
  output logic [WOUT-1:0]      o_left,
  output logic [WOUT-1:0]      o_right,
  output logic                 o_out_valid,
  output logic                 o_clip_l,
  output logic                 o_clip_r
);

  logic                         w_sum_en, w_drop, w_unused_s3;
  logic [NEXT-1:0]              w_hit;
  logic signed [WACC-1:0]       w_fm_sx;
  logic [1:0][WACC-1:0]         w_fm;
  logic [1:0][NEXT*EXTW-1:0]    w_ext;
  logic [1:0][WOUT-1:0]         w_out;
  logic [1:0]                   w_clip;
  logic                         r_primed, r_out_valid;

  assign w_unused_s3 = i_s3_enters;
  assign w_sum_en    = alg_sum_en(i_alg, i_s1_enters, i_s2_enters, i_s4_enters);
  assign w_fm_sx     = WACC'($signed(i_op_result));

  always_comb begin
    for (int i = 0; i < NEXT; i++)
      w_hit[i] = (i_cur_op == 2'd0) && (i_cur_ch == i_ext_ch[i*3 +: 3]) && !i_ext_mute[i];
    w_drop = |(w_hit & i_ext_rep);
    for (int s = 0; s < 2; s++)
      w_fm[s] = (w_sum_en && i_rl[s] && !w_drop) ? w_fm_sx : '0;
  end

  assign w_ext[1] = i_ext_l;
  assign w_ext[0] = i_ext_r;

  // Index 1 = left, 0 = right, matching the rl bit order
  for (genvar s = 0; s < 2; s++) begin : g_lane
    jt12_mix_lane #(.EXTW(EXTW), .NEXT(NEXT), .WACC(WACC), .WOUT(WOUT)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_cen  (i_clk_en),
      .i_zero (i_zero),
      .i_fm   (w_fm[s]),
      .i_ext  (w_ext[s]),
      .i_sh   (i_ext_sh),
      .i_hit  (w_hit),
      .o_out  (w_out[s]),
      .o_clip (w_clip[s])
    );
  end

  // The first frame after reset is partial, so its sample is not announced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= i_clk_en & i_zero & r_primed;
      if (i_clk_en && i_zero) r_primed <= 1'b1;
    end
  end

  assign o_left      = w_out[1];
  assign o_right     = w_out[0];
  assign o_clip_l    = w_clip[1];
  assign o_clip_r    = w_clip[0];
  assign o_out_valid = r_out_valid;

`ifdef JT12_ACC_PEAK_EN
  function automatic logic [WOUT-2:0] mag(input logic [WOUT-1:0] v);
    logic [WOUT-1:0] n;
    n = -v;
    if (!v[WOUT-1]) return v[WOUT-2:0];
    if (n[WOUT-1])  return '1;
    return n[WOUT-2:0];
  endfunction

  logic [WOUT-2:0] r_peak_l, r_peak_r, w_abs_l, w_abs_r;
  assign w_abs_l = mag(o_left);
  assign w_abs_r = mag(o_right);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end else if (r_out_valid) begin
      if (w_abs_l > r_peak_l) r_peak_l <= w_abs_l;
      if (w_abs_r > r_peak_r) r_peak_r <= w_abs_r;
    end else if (i_peak_clr) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end
  end

  assign o_peak_l = r_peak_l;
  assign o_peak_r = r_peak_r;
`endif

endmodule

// File: tb/tb_jt12_mix_acc.sv
// Scoreboard bench for jt12_mix_acc: directed frames plus randomized slots,
// checked against a frame-level arithmetic model.
module tb_jt12_mix_acc;
  import jt12_acc_pkg::*;

  localparam int WIN = 14, EXTW = 16, NEXT = 2, WACC = 19, WOUT = 16;

  logic clk, rst_n, i_clk_en, i_s1_enters, i_s2_enters, i_s3_enters, i_s4_enters, i_zero;
  logic [WIN-1:0]       i_op_result;
  logic [1:0]           i_rl, i_cur_op;
  logic [2:0]           i_alg, i_cur_ch;
  logic [NEXT*EXTW-1:0] i_ext_l, i_ext_r;
  logic [NEXT*3-1:0]    i_ext_ch, i_ext_sh;
  logic [NEXT-1:0]      i_ext_rep, i_ext_mute;
  logic [WOUT-1:0]      o_left, o_right;
  logic                 o_out_valid, o_clip_l, o_clip_r;
`ifdef JT12_ACC_PEAK_EN
  logic                 i_peak_clr;
  logic [WOUT-2:0]      o_peak_l, o_peak_r;
`endif

  jt12_mix_acc #(.WIN(WIN), .EXTW(EXTW), .NEXT(NEXT), .WACC(WACC), .WOUT(WOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_clk_en(i_clk_en), .i_op_result(i_op_result), .i_rl(i_rl),
    .i_alg(i_alg), .i_s1_enters(i_s1_enters), .i_s2_enters(i_s2_enters),
    .i_s3_enters(i_s3_enters), .i_s4_enters(i_s4_enters), .i_cur_ch(i_cur_ch),
    .i_cur_op(i_cur_op), .i_zero(i_zero), .i_ext_l(i_ext_l), .i_ext_r(i_ext_r),
    .i_ext_ch(i_ext_ch), .i_ext_sh(i_ext_sh), .i_ext_rep(i_ext_rep), .i_ext_mute(i_ext_mute),
`ifdef JT12_ACC_PEAK_EN
    .i_peak_clr(i_peak_clr), .o_peak_l(o_peak_l), .o_peak_r(o_peak_r),
`endif
    .o_left(o_left), .o_right(o_right), .o_out_valid(o_out_valid),
    .o_clip_l(o_clip_l), .o_clip_r(o_clip_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Slot stimulus state
  int t_op, t_alg, t_idx;
  bit t_s1, t_s2, t_s3, t_s4, t_zero;
  bit [1:0] t_rl;
  int e_l[NEXT], e_r[NEXT], e_ch[NEXT], e_sh[NEXT];
  bit e_rep[NEXT], e_mute[NEXT];
  int chmap[6] = '{0, 1, 2, 4, 5, 6};

  // Reference model: frame sums with saturating adds
  typedef struct { longint l, r; bit cl, cr; } exp_t;
  exp_t   q[$];
  longint m_acc[2];
  bit     m_stk[2];
  bit     m_primed;

  function automatic longint satw(longint v, int w);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic longint ext_term(longint e, int sh);
    longint m = longint'(1) <<< WACC;
    longint x = (e * (longint'(1) <<< sh)) & (m - 1);
    if (x >= m / 2) x -= m;
    return x >>> 2;
  endfunction

  function automatic void model_reset();
    m_acc = '{0, 0};
    m_stk = '{0, 0};
    m_primed = 0;
  endfunction

  function automatic void model_slot();
    bit en, drop;
    longint ext_sum[2];
    ext_sum = '{0, 0};
    drop = 0;
    case (t_alg)
      0, 1, 2, 3: en = t_s4;
      4:          en = t_s2 | t_s4;
      5, 6:       en = !t_s1;
      default:    en = 1;
    endcase
    for (int i = 0; i < NEXT; i++)
      if (!e_mute[i] && t_idx < 6 && chmap[t_idx % 6] == e_ch[i]) begin
        if (e_rep[i]) drop = 1;
        ext_sum[1] += ext_term(e_l[i], e_sh[i]);
        ext_sum[0] += ext_term(e_r[i], e_sh[i]);
      end
    if (t_zero && m_primed) begin
      exp_t e;
      e.l  = satw(m_acc[1], WOUT);
      e.r  = satw(m_acc[0], WOUT);
      e.cl = m_stk[1] || (e.l != m_acc[1]);
      e.cr = m_stk[0] || (e.r != m_acc[0]);
      q.push_back(e);
    end
    for (int s = 0; s < 2; s++) begin
      longint slot, tot;
      slot = ((en && t_rl[s] && !drop) ? longint'(t_op) : 0) + ext_sum[s];
      tot  = (t_zero ? 0 : m_acc[s]) + slot;
      m_acc[s] = satw(tot, WACC);
      m_stk[s] = (t_zero ? 1'b0 : m_stk[s]) | (m_acc[s] != tot);
    end
    if (t_zero) m_primed = 1;
  endfunction

  task automatic apply_slot();
    i_clk_en    = 1'b1;
    i_zero      = t_zero;
    i_op_result = t_op[WIN-1:0];
    i_alg       = t_alg[2:0];
    i_rl        = t_rl;
    {i_s1_enters, i_s2_enters, i_s3_enters, i_s4_enters} = {t_s1, t_s2, t_s3, t_s4};
    i_cur_op    = 2'(t_idx / 6);
    i_cur_ch    = chmap[t_idx % 6][2:0];
    for (int i = 0; i < NEXT; i++) begin
      i_ext_l[i*EXTW +: EXTW] = e_l[i][EXTW-1:0];
      i_ext_r[i*EXTW +: EXTW] = e_r[i][EXTW-1:0];
      i_ext_ch[i*3 +: 3]      = e_ch[i][2:0];
      i_ext_sh[i*3 +: 3]      = e_sh[i][2:0];
      i_ext_rep[i]            = e_rep[i];
      i_ext_mute[i]           = e_mute[i];
    end
    if (rst_n) model_slot();
    @(posedge clk); #1;
  endtask

  task automatic zslot();
    t_idx = 0; t_zero = 1; apply_slot();
  endtask

  task automatic rest(int n);
    for (int k = 0; k < n; k++) begin
      t_idx = (t_idx + 1) % FRAME_SLOTS; t_zero = 0; apply_slot();
    end
  endtask

  task automatic idle(int n);
    i_clk_en = 1'b0;
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(int op, int alg, bit [1:0] rl);
    t_op = op; t_alg = alg; t_rl = rl;
    {t_s1, t_s2, t_s3, t_s4} = 4'b0;
    for (int i = 0; i < NEXT; i++) begin
      e_l[i] = 0; e_r[i] = 0; e_ch[i] = 0; e_sh[i] = 0; e_rep[i] = 0; e_mute[i] = 1;
    end
  endtask

  task automatic rnd_slot();
    t_op  = int'($urandom_range(0, 16383)) - 8192;
    t_alg = int'($urandom_range(0, 7));
    t_rl  = 2'($urandom_range(0, 3));
    {t_s1, t_s2, t_s3, t_s4} = 4'($urandom_range(0, 15));
  endtask

  // Monitor: every out_valid pops one expected frame
  always @(negedge clk) begin
    if (rst_n && o_out_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_unexpected_valid: got out_valid=1 expected no frame at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_left", longint'($signed(o_left)), e.l);
        chk("sb_right", longint'($signed(o_right)), e.r);
        chk("sb_clip_l", longint'(o_clip_l), longint'(e.cl));
        chk("sb_clip_r", longint'(o_clip_r), longint'(e.cr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_clk_en = 1'b0; i_zero = 1'b0; t_idx = 0;
`ifdef JT12_ACC_PEAK_EN
    i_peak_clr = 1'b0;
`endif
    cfg(0, 7, 2'b11);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", longint'($signed(o_left)), 0);
    chk("rst_right", longint'($signed(o_right)), 0);
    chk("rst_valid", longint'(o_out_valid), 0);
    chk("rst_clip", longint'({o_clip_l, o_clip_r}), 0);
    rst_n = 1'b1;
    idle(2);

    // Plain 24-slot frame, first zero is discarded
    cfg(100, 7, 2'b11);
    zslot();
    chk("first_zero_valid", longint'(o_out_valid), 0);
    chk("first_zero_left", longint'($signed(o_left)), 0);
    rest(23);

    // Stream 0 replaces channel-2 slot
    cfg(500, 7, 2'b11);
    e_l[0] = 1000; e_ch[0] = 2; e_sh[0] = 6; e_rep[0] = 1; e_mute[0] = 0;
    zslot();
    chk("f1_valid", longint'(o_out_valid), 1);
    chk("f1_left", longint'($signed(o_left)), 2400);
    chk("f1_right", longint'($signed(o_right)), 2400);
    chk("f1_clip", longint'({o_clip_l, o_clip_r}), 0);
    rest(23);

    cfg(8191, 7, 2'b11);
    zslot();
    chk("ext_left", longint'($signed(o_left)), 27500);
    chk("ext_right", longint'($signed(o_right)), 11500);
    rest(23);

    cfg(0, 7, 2'b11);
    zslot();
    chk("sat_left", longint'($signed(o_left)), 32767);
    chk("sat_clip_l", longint'(o_clip_l), 1);
    rest(23);

    // Right-only, alg 0 with one s4 slot
    cfg(-200, 0, 2'b01);
    zslot();
    chk("unsat_left", longint'($signed(o_left)), 0);
    chk("unsat_clip_l", longint'(o_clip_l), 0);
    rest(4);
    t_s4 = 1; rest(1); t_s4 = 0;
    rest(18);

    cfg(100, 7, 2'b11);
    zslot();
    chk("rl_left", longint'($signed(o_left)), 0);
    chk("rl_right", longint'($signed(o_right)), -200);

    // Reset at slot 10, released at slot 15
    rest(9);
    rst_n = 1'b0;
    model_reset();
    q.delete();
    #1;
    chk("midrst_left", longint'($signed(o_left)), 0);
    chk("midrst_valid", longint'(o_out_valid), 0);
    rest(5);
    rst_n = 1'b1;
    rest(9);
    chk("postrst_left", longint'($signed(o_left)), 0);
    zslot();
    chk("postrst_zero_valid", longint'(o_out_valid), 0);
    chk("postrst_zero_left", longint'($signed(o_left)), 900);
    rest(23);
    zslot();
    chk("postrst_second_valid", longint'(o_out_valid), 1);
    chk("postrst_second_left", longint'($signed(o_left)), 2400);
    rest(23);

    // Randomized frames, including short and 1-slot frames
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : FRAME_SLOTS;
      for (int i = 0; i < NEXT; i++) begin
        e_l[i]    = int'($urandom_range(0, 65535)) - 32768;
        e_r[i]    = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 1) == 1) begin
          e_l[i] = e_l[i] / 64; e_r[i] = e_r[i] / 64;
        end
        e_ch[i]   = int'($urandom_range(0, 7));
        e_sh[i]   = int'($urandom_range(0, 7));
        e_rep[i]  = 1'($urandom_range(0, 1));
        e_mute[i] = ($urandom_range(0, 3) == 0);
      end
      rnd_slot();
      zslot();
      for (int k = 1; k < len; k++) begin
        rnd_slot();
        rest(1);
      end
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    cfg(0, 7, 2'b11);
    zslot();
    rest(1);

`ifdef JT12_ACC_PEAK_EN
    cfg(-8192, 7, 2'b11);
    zslot();
    rest(23);
    idle(1);
    i_peak_clr = 1'b1; idle(1); i_peak_clr = 1'b0;
    chk("peak_clr0", longint'(o_peak_l), 0);
    cfg(100, 0, 2'b11);
    t_s4 = 1; zslot(); t_s4 = 0;
    rest(23);
    cfg(0, 7, 2'b11);
    zslot();
    idle(1);
    chk("peak_l", longint'(o_peak_l), 32767);
    chk("peak_r", longint'(o_peak_r), 32767);
    i_peak_clr = 1'b1; idle(1); i_peak_clr = 1'b0;
    chk("peak_clr_l", longint'(o_peak_l), 0);
    chk("peak_clr_r", longint'(o_peak_r), 0);
`endif

    idle(3);
    chk("sb_drained", longint'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
